// File: rtl/tx_fifo_sched_if.sv
// Handshake/bus bundle between the transmit FIFO scheduler and its surroundings.
// master: requester + FIFO status + serializer ready (drives the scheduler inputs).
// slave : the scheduler itself (drives pop strobe, word qualifiers, status).
interface tx_fifo_sched_if #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int LEN_W           = 8,
  parameter int CNT_W           = 5
);
  localparam int SIDE_W = $clog2(WORDS_PER_BLOCK);

  // requester / FIFO / serializer side
  logic              start;
  logic [LEN_W-1:0]  num_blocks;
  logic              abort;
  logic              empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              ser_ready;
  // scheduler side
  logic              tx_deq_word;
  logic              word_valid;
  logic              word_last;
  logic [SIDE_W-1:0] side;
  logic [LEN_W-1:0]  blocks_left;
  logic              busy;
  logic              done;
  logic              timeout;

  modport master (
    output start, num_blocks, abort, empty, fifo_count, ser_ready,
    input  tx_deq_word, word_valid, word_last, side, blocks_left, busy, done, timeout
  );

  modport slave (
    input  start, num_blocks, abort, empty, fifo_count, ser_ready,
    output tx_deq_word, word_valid, word_last, side, blocks_left, busy, done, timeout
  );
endinterface

// File: rtl/tx_fifo_sched.sv
// Purpose : drains num_blocks whole blocks (WORDS_PER_BLOCK words each) from the
//           transmit FIFO into the serializer, owning the pop strobe and side index.
// Latency : start -> WAIT_BLK next cycle; first pop one cycle after a whole block is seen.
// Backpress: a word pops only when FIFO non-empty and ser_ready; stalls hold side/blocks_left.
// Ports   : clk, n_rst (async active-low) plus bus (tx_fifo_sched_if.slave):
//           in  start/num_blocks/abort, empty/fifo_count, ser_ready
//           out tx_deq_word, word_valid, word_last, side, blocks_left, busy, done, timeout
// Option  : TX_SCHED_TIMEOUT_EN enables the WAIT_BLK timeout (TIMEOUT_CYC); otherwise
//           the scheduler waits indefinitely and timeout is tied low.
module tx_fifo_sched #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int LEN_W           = 8,
  parameter int CNT_W           = 5,
  parameter int TIMEOUT_CYC     = 255
) (
  input  logic          clk,
  input  logic          n_rst,
  tx_fifo_sched_if.slave bus
);
  localparam int                SIDE_W    = $clog2(WORDS_PER_BLOCK);
  localparam logic [SIDE_W-1:0] SIDE_LAST = SIDE_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  BLK_WORDS = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [LEN_W-1:0]  ONE_BLK   = LEN_W'(1);

  // Side index relies on natural wrap, so the block size must be a power of two.
  if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 ||
      TIMEOUT_CYC < 1) begin : g_param_check
    $error("tx_fifo_sched: bad WORDS_PER_BLOCK or TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {IDLE, WAIT_BLK, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic [LEN_W-1:0]  blocks_q, blocks_d;
  logic              wvld;
  logic              pop;
  logic              timeout_c;

`ifdef TX_SCHED_TIMEOUT_EN
  localparam int               WAIT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  // Head word is offered whenever we are sending and the FIFO has something.
  assign wvld = (state_q == SEND) && !bus.empty;
  // abort wins over a handshake: no word leaves the FIFO in the abort cycle.
  assign pop  = wvld && bus.ser_ready && !bus.abort;

  assign bus.word_valid  = wvld;
  assign bus.tx_deq_word = pop;
  assign bus.word_last   = wvld && (side_q == SIDE_LAST) && (blocks_q == ONE_BLK);
  assign bus.side        = side_q;
  assign bus.blocks_left = blocks_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.timeout     = timeout_c;

  always_comb begin
    state_d   = state_q;
    side_d    = side_q;
    blocks_d  = blocks_q;
    timeout_c = 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
    // Counter sits at zero outside WAIT_BLK, so every entry starts a fresh wait.
    wait_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          side_d = '0;
          if (bus.num_blocks != '0) begin
            blocks_d = bus.num_blocks;
            state_d  = WAIT_BLK;
          end else begin
            blocks_d = '0;
            state_d  = DONE;
          end
        end
      end
      WAIT_BLK: begin
        if (bus.fifo_count >= BLK_WORDS) begin
          state_d = SEND;
        end
`ifdef TX_SCHED_TIMEOUT_EN
        else if (wait_q == WAIT_MAX) begin
          timeout_c = 1'b1;
          state_d   = IDLE;
          side_d    = '0;
          blocks_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      SEND: begin
        if (pop) begin
          side_d = side_q + 1'b1;
          if (side_q == SIDE_LAST) begin
            // Block complete: each further block must be re-qualified in WAIT_BLK.
            blocks_d = blocks_q - ONE_BLK;
            state_d  = (blocks_q == ONE_BLK) ? DONE : WAIT_BLK;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      side_d    = '0;
      blocks_d  = '0;
      timeout_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      side_q   <= '0;
      blocks_q <= '0;
    end else begin
      state_q  <= state_d;
      side_q   <= side_d;
      blocks_q <= blocks_d;
    end
  end

`ifdef TX_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

endmodule

// File: tb/tb_tx_fifo_sched.sv
// Directed, table-driven bench for tx_fifo_sched (WORDS_PER_BLOCK=4, LEN_W=8, CNT_W=5).
// Each table row is one clock cycle: inputs driven after the falling edge, outputs
// compared shortly after, before the next rising edge.
module tb_tx_fifo_sched;
  logic clk = 1'b0;
  logic n_rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tx_fifo_sched_if #(.WORDS_PER_BLOCK(4), .LEN_W(8), .CNT_W(5)) bus ();

  tx_fifo_sched #(
    .WORDS_PER_BLOCK(4), .LEN_W(8), .CNT_W(5), .TIMEOUT_CYC(10)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  typedef struct {
    logic        start;
    logic [7:0]  nb;
    logic        abort;
    logic        empty;
    logic [4:0]  fc;
    logic        rdy;
    logic [15:0] exp;   // {deq, valid, last, side[1:0], blocks_left[7:0], busy, done, timeout}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic st, input int nb, input logic ab, input logic em,
                             input int fc, input logic rd, input logic dq, input logic wv,
                             input logic wl, input int sd, input int bl, input logic bz,
                             input logic dn);
    vec_t r;
    logic [7:0] nbv;
    logic [4:0] fcv;
    logic [1:0] sdv;
    logic [7:0] blv;
    nbv = nb[7:0];
    fcv = fc[4:0];
    sdv = sd[1:0];
    blv = bl[7:0];
    r.start = st; r.nb = nbv; r.abort = ab; r.empty = em; r.fc = fcv; r.rdy = rd;
    r.exp   = {dq, wv, wl, sdv, blv, bz, dn, 1'b0};
    return r;
  endfunction

  function automatic logic [15:0] outs();
    return {bus.tx_deq_word, bus.word_valid, bus.word_last, bus.side, bus.blocks_left,
            bus.busy, bus.done, bus.timeout};
  endfunction

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] nb, input logic ab,
                       input logic em, input logic [4:0] fc, input logic rd);
    bus.start = st; bus.num_blocks = nb; bus.abort = ab;
    bus.empty = em; bus.fifo_count = fc; bus.ser_ready = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Two blocks with data ready: one WAIT_BLK cycle between blocks; start while busy ignored.
    vecs.push_back(v(1,2,0,0,8,1, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,8,1, 0,0,0,0,2,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,0,2,1,0));
    vecs.push_back(v(1,5,0,0,8,1, 1,1,0,1,2,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,2,2,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,3,2,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 0,0,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,1,1,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,2,1,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,1,3,1,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 0,0,0,0,0,1,1));
    vecs.push_back(v(0,0,0,0,8,1, 0,0,0,0,0,0,0));
    // Partial block waits; underflow (empty) in SEND holds side.
    vecs.push_back(v(1,1,0,0,3,1, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,3,1, 0,0,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,3,1, 0,0,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 0,0,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 1,1,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 1,1,0,1,1,1,0));
    vecs.push_back(v(0,0,0,1,4,1, 0,0,0,2,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 1,1,0,2,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 1,1,1,3,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 0,0,0,0,0,1,1));
    vecs.push_back(v(0,0,0,0,4,1, 0,0,0,0,0,0,0));
    // Serializer stalls on alternate cycles.
    vecs.push_back(v(1,1,0,0,4,1, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,4,0, 0,0,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 1,1,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,4,0, 0,1,0,1,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 1,1,0,1,1,1,0));
    vecs.push_back(v(0,0,0,0,4,0, 0,1,0,2,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 1,1,0,2,1,1,0));
    vecs.push_back(v(0,0,0,0,4,0, 0,1,1,3,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 1,1,1,3,1,1,0));
    vecs.push_back(v(0,0,0,0,4,1, 0,0,0,0,0,1,1));
    vecs.push_back(v(0,0,0,0,4,1, 0,0,0,0,0,0,0));
    // Zero-block request goes straight to DONE without pops.
    vecs.push_back(v(1,0,0,0,4,1, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,4,1, 0,0,0,0,0,1,1));
    vecs.push_back(v(0,0,0,0,4,1, 0,0,0,0,0,0,0));
    // Abort after the 2nd pop, then restart from side 0.
    vecs.push_back(v(1,2,0,0,8,1, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,8,1, 0,0,0,0,2,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,0,2,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,1,2,1,0));
    vecs.push_back(v(0,0,1,0,8,1, 0,1,0,2,2,1,0));
    vecs.push_back(v(1,1,0,0,8,1, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,8,1, 0,0,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,0,1,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,1,1,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,0,2,1,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 1,1,1,3,1,1,0));
    vecs.push_back(v(0,0,0,0,8,1, 0,0,0,0,0,1,1));
    vecs.push_back(v(0,0,0,0,8,1, 0,0,0,0,0,0,0));
    // Abort while waiting for a block.
    vecs.push_back(v(1,3,0,0,2,1, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,1,0,2,1, 0,0,0,0,3,1,0));
    vecs.push_back(v(0,0,0,0,2,1, 0,0,0,0,0,0,0));

    n_rst = 1'b0;
    drive(0, 8'd0, 0, 1'b1, 5'd0, 0);
    #3;
    check("reset_state", int'(outs()), 0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].start, vecs[i].nb, vecs[i].abort, vecs[i].empty, vecs[i].fc, vecs[i].rdy);
      #1;
      checks++;
      if (outs() !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d {deq,vld,last,side,blk,busy,done,to}: got=%h expected=%h",
                 i, outs(), vecs[i].exp);
      end
    end

    // Asynchronous reset in the middle of a block.
    @(negedge clk); drive(1, 8'd1, 0, 0, 5'd4, 1);
    @(negedge clk); drive(0, 8'd0, 0, 0, 5'd4, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_send_before_reset", int'(outs()), int'({1'b1, 1'b1, 1'b0, 2'd1, 8'd1, 3'b100}));
    #2 n_rst = 1'b0;
    #1;
    check("async_reset_outputs", int'(outs()), 0);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("after_reset_idle", int'(outs()), 0);
    @(negedge clk); drive(1, 8'd1, 0, 0, 5'd4, 1);
    @(negedge clk); drive(0, 8'd0, 0, 0, 5'd4, 1);
    #1;
    check("restart_wait_blk", int'(outs()), int'({3'b000, 2'd0, 8'd1, 3'b100}));
    for (int c = 0; c < 6; c++) @(negedge clk);
    #1;
    check("restart_completes_busy", int'(bus.busy), 0);

`ifdef TX_SCHED_TIMEOUT_EN
    begin
      int to_cnt;
      int to_at;
      int done_cnt;
      to_cnt = 0; to_at = -1; done_cnt = 0;
      @(negedge clk); drive(1, 8'd1, 0, 0, 5'd0, 1);
      @(negedge clk); drive(0, 8'd0, 0, 0, 5'd0, 1);
      for (int c = 0; c < 40; c++) begin
        #1;
        if (bus.timeout) begin to_cnt++; to_at = c; end
        if (bus.done) done_cnt++;
        @(negedge clk);
      end
      check("timeout_pulse_count", to_cnt, 1);
      check("timeout_cycle", to_at, 10);
      check("timeout_no_done", done_cnt, 0);
      #1;
      check("timeout_back_idle", int'(outs()), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
